// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage RV32I pipeline: PC register, instruction
// memory addressing and the IF/ID pipeline register, with stall, redirect and halt.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic        fetch_fault
);

    localparam logic [31:0] PC_LIMIT    = 32'(4 * IMEM_WORDS);
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [1:0] {
        RUN,
        HALT_BRK,
        HALT_FAULT
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] inst_reg, inst_next;
    logic [31:0] id_pc_reg, id_pc_next;
    logic [31:0] id_pc4_reg, id_pc4_next;
    logic        valid_reg, valid_next;
    logic        halted_reg, halted_next;
    logic        fault_reg, fault_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= RUN;
            pc_reg     <= RESET_PC;
            inst_reg   <= NOP_INST;
            id_pc_reg  <= 32'h0;
            id_pc4_reg <= 32'h0;
            valid_reg  <= 1'b0;
            halted_reg <= 1'b0;
            fault_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            inst_reg   <= inst_next;
            id_pc_reg  <= id_pc_next;
            id_pc4_reg <= id_pc4_next;
            valid_reg  <= valid_next;
            halted_reg <= halted_next;
            fault_reg  <= fault_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        inst_next   = inst_reg;
        id_pc_next  = id_pc_reg;
        id_pc4_next = id_pc4_reg;
        valid_next  = valid_reg;
        fault_next  = fault_reg;

        if (redirect) begin
            // A redirect comes from an older instruction, so it also cancels any halt.
            pc_next     = {redirect_pc[31:2], 2'b00};
            inst_next   = NOP_INST;
            id_pc_next  = 32'h0;
            id_pc4_next = 32'h0;
            valid_next  = 1'b0;
            state_next  = RUN;
            fault_next  = 1'b0;
        end else if (stall) begin
            // hold everything
        end else if (state_reg != RUN) begin
            inst_next   = NOP_INST;
            id_pc_next  = 32'h0;
            id_pc4_next = 32'h0;
            valid_next  = 1'b0;
        end else if (pc_reg >= PC_LIMIT) begin
            inst_next   = NOP_INST;
            id_pc_next  = 32'h0;
            id_pc4_next = 32'h0;
            valid_next  = 1'b0;
            state_next  = HALT_FAULT;
            fault_next  = 1'b1;
        end else begin
            inst_next   = imem_data;
            id_pc_next  = pc_reg;
            id_pc4_next = pc_reg + 32'd4;
            valid_next  = 1'b1;
            // ebreak is still handed to ID, but the PC stays on it.
            if (imem_data == EBREAK_INST) begin
                state_next = HALT_BRK;
            end else begin
                pc_next = pc_reg + 32'd4;
            end
        end

        halted_next = (state_next != RUN);
    end

    assign imem_addr   = pc_reg;
    assign if_id_inst  = inst_reg;
    assign if_id_pc    = id_pc_reg;
    assign if_id_pc4   = id_pc4_reg;
    assign if_id_valid = valid_reg;
    assign halted      = halted_reg;
    assign fetch_fault = fault_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios followed by random
// stall/redirect/reset traffic, checked against a behavioural fetch model.
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam int          WORDS  = 64;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc, imem_data, imem_addr;
    logic [31:0] if_id_inst, if_id_pc, if_id_pc4;
    logic        if_id_valid, halted, fetch_fault;

    logic [31:0] mem [WORDS];

    fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_data(imem_data), .imem_addr(imem_addr),
        .if_id_inst(if_id_inst), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .halted(halted), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 32'(4 * WORDS)) ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
        logic        fault;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passes = 0;
    int txn    = 0;

    // Reference model: what the fetch unit "knows" after each edge.
    logic [31:0] m_pc;
    exp_t        m_out;
    bit          m_stopped;
    bit          m_fault;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (txn %0d)", name, act, exp, txn);
    endtask

    task automatic bubble();
        m_out.inst  = NOP;
        m_out.pc    = 32'h0;
        m_out.pc4   = 32'h0;
        m_out.valid = 1'b0;
    endtask

    task automatic step(input bit r, input bit s, input bit d, input logic [31:0] rpc);
        logic [31:0] word;
        @(negedge clk);
        rst = r; stall = s; redirect = d; redirect_pc = rpc;
        if (r) begin
            m_pc = 32'h0; bubble(); m_stopped = 0; m_fault = 0;
        end else if (d) begin
            m_pc = rpc & ~32'h3; bubble(); m_stopped = 0; m_fault = 0;
        end else if (s) begin
            // frozen
        end else if (m_stopped) begin
            bubble();
        end else if (m_pc >= 32'(4 * WORDS)) begin
            bubble(); m_stopped = 1; m_fault = 1;
        end else begin
            word = mem[m_pc / 4];
            m_out.inst  = word;
            m_out.pc    = m_pc;
            m_out.pc4   = m_pc + 4;
            m_out.valid = 1'b1;
            if (word == EBREAK) m_stopped = 1;
            else m_pc = m_pc + 4;
        end
        m_out.addr   = m_pc;
        m_out.halted = m_stopped;
        m_out.fault  = m_fault;
        q.push_back(m_out);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0);
    endtask

    // Monitor: one expected entry per edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                txn++;
                chk("imem_addr",   imem_addr,   e.addr);
                chk("if_id_inst",  if_id_inst,  e.inst);
                chk("if_id_pc",    if_id_pc,    e.pc);
                chk("if_id_pc4",   if_id_pc4,   e.pc4);
                chk("if_id_valid", 32'(if_id_valid), 32'(e.valid));
                chk("halted",      32'(halted),      32'(e.halted));
                chk("fetch_fault", 32'(fetch_fault), 32'(e.fault));
                $display("txn %0d: addr=%h inst=%h pc=%h v=%b halt=%b flt=%b",
                         txn, imem_addr, if_id_inst, if_id_pc, if_id_valid, halted, fetch_fault);
            end
        end
    end

    initial begin
        logic [31:0] w;
        int          roll;
        logic [31:0] rpc;
        for (int i = 0; i < WORDS; i++) begin
            do w = $urandom(); while (w == EBREAK);
            mem[i] = w;
        end
        mem[12] = EBREAK;       // 0x30
        mem[40] = 32'h0000_0073; // ecall passes through untouched
        mem[50] = EBREAK;
        rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
        m_pc = 0; m_out = '0; m_stopped = 0; m_fault = 0;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        run(4);                      // fetch 0x0..0xC
        step(0, 1, 0, 0);            // stall at 0x10
        step(0, 1, 0, 0);
        run(1);                      // resume with 0x10
        step(0, 1, 1, 32'h23);       // redirect beats stall
        run(7);                      // 0x20..0x30 ebreak, then bubbles
        step(0, 0, 1, 32'h8);        // leave HALT_BRK
        run(3);
        step(0, 0, 1, 32'hF0);
        run(6);                      // runs off the end into HALT_FAULT
        step(0, 1, 0, 0);            // stall while faulted
        step(1, 0, 0, 0);            // reset out of fault
        run(2);
        step(1, 1, 0, 0);            // reset during stall
        step(1, 0, 1, 32'h40);       // reset beats redirect
        step(0, 0, 1, 32'hFFFF_FFFC);
        run(2);                      // far out-of-range target faults

        for (int i = 0; i < 400; i++) begin
            roll = int'($urandom_range(0, 99));
            rpc  = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 32'h11F));
            if (roll < 2)       step(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rpc);
            else if (roll < 12) step(0, $urandom_range(0, 1) == 1, 1, rpc);
            else if (roll < 35) step(0, 1, 0, rpc);
            else                step(0, 0, 0, rpc);
        end

        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
